// File: rtl/deserializador_pkg.sv
// Shared types and helpers for the serial-to-parallel loader FSM.
// The state encoding is fixed here so the FSM and any observers agree on it.
package deserializador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    LOAD  = 2'b10
  } estado_t;

  localparam int unsigned N_DEFAULT        = 8;
  localparam int unsigned W_FRAMES_DEFAULT = 8;

endpackage

// File: rtl/contador_param.sv
// Parameterised wrapping counter with synchronous active-low reset,
// synchronous clear (priority over enable) and count enable.
module contador_param #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/deserializador_fsm.sv
// Serial-to-parallel loader: assembles N MSB-first bits after a start strobe,
// then presents the word on d with a one-cycle en strobe for a downstream register.
module deserializador_fsm
  import deserializador_pkg::*;
#(
  parameter int unsigned N        = N_DEFAULT,
  parameter int unsigned W_FRAMES = W_FRAMES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                bit_valid,
  input  logic                bit_in,
  output logic [N-1:0]        d,
  output logic                en,
  output logic                busy,
  output logic [W_FRAMES-1:0] frame_count
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  estado_t          state_q, state_d;
  logic [N-1:0]     sh_q, sh_d;
  logic [N-1:0]     d_q, d_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_clr, cnt_inc, frm_inc;
  logic [N-1:0]     shifted;

  assign shifted = {sh_q[N-2:0], bit_in};

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    d_d     = d_q;
    en_d    = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    frm_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sh_d    = '0;
          cnt_clr = 1'b1;
        end
      end
      SHIFT: begin
        if (start) begin
          sh_d    = '0;
          cnt_clr = 1'b1;
        end else if (bit_valid) begin
          sh_d = shifted;
          // The last bit clears the counter so it never runs past N-1.
          if (cnt_q == LAST_BIT) begin
            state_d = LOAD;
            d_d     = shifted;
            en_d    = 1'b1;
            frm_inc = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      LOAD: begin
        if (start) begin
          state_d = SHIFT;
          sh_d    = '0;
          cnt_clr = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      d_q     <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      d_q     <= d_d;
      en_q    <= en_d;
    end
  end

  contador_param #(.W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_inc),
    .q_o   (cnt_q)
  );

  contador_param #(.W(W_FRAMES)) u_frame_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .en_i  (frm_inc),
    .q_o   (frame_count)
  );

  assign d    = d_q;
  assign en   = en_q;
  assign busy = (state_q == SHIFT) || (state_q == LOAD);

endmodule

// File: tb/tb_deserializador_fsm.sv
// Bench for deserializador_fsm: a W_FRAMES=8 instance and a W_FRAMES=2 instance
// share stimulus; expected loads are queued as the last bit is driven.
module tb_deserializador_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic [7:0] d, d2;
  logic       en, en2, busy, busy2;
  logic [7:0] fc;
  logic [1:0] fc2;

  typedef struct {
    logic [7:0] word;
    int         frames;
  } exp_t;

  exp_t sb[$];
  int   exp_frames = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  always #5 clk = ~clk;

  deserializador_fsm #(.N(8), .W_FRAMES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .d(d), .en(en), .busy(busy), .frame_count(fc)
  );

  deserializador_fsm #(.N(8), .W_FRAMES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .d(d2), .en(en2), .busy(busy2), .frame_count(fc2)
  );

  always @(negedge clk) begin
    if (mon_on && (en !== 1'b0 || en2 !== 1'b0)) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_en en=%b en2=%b d=%h expected no load", en, en2, d);
      end else begin
        e = sb.pop_front();
        if (en !== 1'b1 || en2 !== 1'b1 || d !== e.word || d2 !== e.word ||
            fc !== 8'(e.frames) || fc2 !== 2'(e.frames)) begin
          errors++;
          $display("FAIL load en=%b en2=%b d=%h d2=%h fc=%0d fc2=%0d expected d=%h fc=%0d fc2=%0d",
                   en, en2, d, d2, fc, fc2, e.word, 8'(e.frames), 2'(e.frames));
        end
      end
    end
  end

  task automatic drive(input logic st, input logic bv, input logic bi);
    @(posedge clk);
    #1;
    start = st; bit_valid = bv; bit_in = bi;
  endtask

  task automatic send_bits(input logic [7:0] word, input bit gap);
    for (int i = 7; i >= 0; i--) begin
      if (gap) drive(1'b0, 1'b0, 1'b1);
      if (i == 0) begin
        exp_frames++;
        sb.push_back('{word: word, frames: exp_frames});
      end
      drive(1'b0, 1'b1, word[i]);
    end
  endtask

  // Called one cycle after the last bit was driven: the block is in LOAD.
  task automatic check_load_cycle(input string name, input logic [7:0] word);
    checks++;
    if (en !== 1'b1 || busy !== 1'b1 || d !== word) begin
      errors++;
      $display("FAIL %s_load en=%b busy=%b d=%h expected en=1 busy=1 d=%h", name, en, busy, d, word);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (en !== 1'b0 || busy !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle en=%b busy=%b busy2=%b expected 0 0 0", name, en, busy, busy2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (d !== 8'h00 || en !== 1'b0 || busy !== 1'b0 || fc !== 8'd0 ||
        d2 !== 8'h00 || en2 !== 1'b0 || busy2 !== 1'b0 || fc2 !== 2'd0) begin
      errors++;
      $display("FAIL reset d=%h en=%b busy=%b fc=%0d d2=%h fc2=%0d expected all zero",
               d, en, busy, fc, d2, fc2);
    end
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic test_contiguous();
    drive(1'b1, 1'b1, 1'b1);
    send_bits(8'hB2, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check_load_cycle("contig", 8'hB2);
    checks++;
    if (fc !== 8'd1) begin
      errors++;
      $display("FAIL contig_count fc=%0d expected 1", fc);
    end
    drive(1'b0, 1'b0, 1'b0);
    check_idle("contig");
  endtask

  task automatic test_gapped();
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 4; i--) begin
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, (8'hB2 >> i) & 1'b1);
    end
    checks++;
    if (d !== 8'hB2 || en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL gapped_hold d=%h en=%b busy=%b expected d=b2 en=0 busy=1", d, en, busy);
    end
    for (int i = 3; i >= 0; i--) begin
      drive(1'b0, 1'b0, 1'b1);
      if (i == 0) begin
        exp_frames++;
        sb.push_back('{word: 8'hB2, frames: exp_frames});
      end
      drive(1'b0, 1'b1, (8'hB2 >> i) & 1'b1);
    end
    drive(1'b0, 1'b0, 1'b1);
    check_load_cycle("gapped", 8'hB2);
    drive(1'b0, 1'b0, 1'b0);
    check_idle("gapped");
    checks++;
    if (fc !== 8'd2) begin
      errors++;
      $display("FAIL gapped_count fc=%0d expected 2", fc);
    end
  endtask

  task automatic test_restart();
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, i[0]);
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1 || en !== 1'b0) begin
      errors++;
      $display("FAIL restart_shift busy=%b en=%b expected 1 0", busy, en);
    end
    send_bits(8'hFF, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check_load_cycle("restart", 8'hFF);
    drive(1'b0, 1'b0, 1'b0);
    check_idle("restart");
    checks++;
    if (fc !== 8'd3) begin
      errors++;
      $display("FAIL restart_count fc=%0d expected 3", fc);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b0);
    send_bits(8'h3C, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check_load_cycle("b2b_first", 8'h3C);
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1 || en !== 1'b0 || d !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_no_idle busy=%b en=%b d=%h expected 1 0 3c", busy, en, d);
    end
    for (int i = 6; i >= 0; i--) begin
      if (i == 0) begin
        exp_frames++;
        sb.push_back('{word: 8'h0F, frames: exp_frames});
      end
      drive(1'b0, 1'b1, (8'h0F >> i) & 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0);
    check_load_cycle("b2b_second", 8'h0F);
    checks++;
    if (fc !== 8'd5 || fc2 !== 2'd1) begin
      errors++;
      $display("FAIL b2b_count fc=%0d fc2=%0d expected 5 1", fc, fc2);
    end
    drive(1'b0, 1'b0, 1'b0);
    check_idle("b2b");
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1; bit_valid = 1'b0;
    exp_frames = 0;
    checks++;
    if (d !== 8'h00 || en !== 1'b0 || busy !== 1'b0 || fc !== 8'd0 || fc2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid d=%h en=%b busy=%b fc=%0d fc2=%0d expected 00 0 0 0 0",
               d, en, busy, fc, fc2);
    end
    drive(1'b1, 1'b0, 1'b0);
    send_bits(8'hA5, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check_load_cycle("after_reset", 8'hA5);
    checks++;
    if (fc !== 8'd1) begin
      errors++;
      $display("FAIL after_reset_count fc=%0d expected 1", fc);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    logic [7:0] words [3] = '{8'h5A, 8'h81, 8'h7E};
    for (int f = 0; f < 3; f++) begin
      drive(1'b1, 1'b0, 1'b0);
      send_bits(words[f], (f == 1));
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (fc2 !== 2'd0 || fc !== 8'd4 || d2 !== 8'h7E) begin
      errors++;
      $display("FAIL wrap fc2=%0d fc=%0d d2=%h expected 0 4 7e", fc2, fc, d2);
    end
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_gapped();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_loads pending=%0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
